// File: rtl/gpr_file_sb_if.sv
// Operand-read, writeback, PC and scoreboard signals of the ID-stage register file.
interface gpr_file_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              pc_wr_en;
  logic [DATA_W-1:0] pc_wr_data;
  logic [DATA_W-1:0] pc_rd;
  logic              pend_en;
  logic [ADDR_W-1:0] pend_addr;
  logic              flush;

  // Pipeline side: decode, writeback and fetch drive requests, sample results.
  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           pc_wr_en, pc_wr_data, pend_en, pend_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, pc_rd
  );

  // Register file side.
  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           pc_wr_en, pc_wr_data, pend_en, pend_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, pc_rd
  );
endinterface

// File: rtl/gpr_file_sb.sv
// General-purpose register file with a PC slot, optional write-through bypass
// and a one-bit-per-register pending scoreboard for hazard detection.
module gpr_file_sb #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       PC_IDX   = 7,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int unsigned       BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  gpr_file_sb_if.slave bus
);
  localparam int unsigned       NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;
  logic [DATA_W-1:0] pc_d;
  logic              wr_hit1;
  logic              wr_hit2;

  // PC slot next value: WB write beats the fetch-path update, else hold.
  always_comb begin
    pc_d = regs_q[PC_A];
    if (bus.wr_en && (bus.wr_addr == PC_A)) begin
      pc_d = bus.wr_data;
    end else if (bus.pc_wr_en) begin
      pc_d = bus.pc_wr_data;
    end
  end

  // Next register contents; regs_d doubles as the bypass source.
  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && (bus.wr_addr != PC_A)) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
    regs_d[PC_A] = pc_d;
  end

  // Scoreboard next state: flush, then issue-set, then writeback-clear.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    idx    = '0;
    pend_d = pend_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      idx = ADDR_W'(r);
      if (bus.flush) begin
        pend_d[idx] = 1'b0;
      end else if (bus.pend_en && (bus.pend_addr == idx) && (idx != PC_A)) begin
        pend_d[idx] = 1'b1;
      end else if (bus.wr_en && (bus.wr_addr == idx)) begin
        pend_d[idx] = 1'b0;
      end
    end
  end

  // State update; reset wins over every same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[ADDR_W'(r)] <= (ADDR_W'(r) == PC_A) ? RESET_PC : '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Combinational read ports and hazard flags.
  always_comb begin
    wr_hit1 = bus.wr_en && (bus.wr_addr == bus.rd_addr1);
    wr_hit2 = bus.wr_en && (bus.wr_addr == bus.rd_addr2);
    if (BYPASS != 0) begin
      bus.rd_data1 = regs_d[bus.rd_addr1];
      bus.rd_data2 = regs_d[bus.rd_addr2];
      bus.rd_busy1 = pend_q[bus.rd_addr1] & ~wr_hit1;
      bus.rd_busy2 = pend_q[bus.rd_addr2] & ~wr_hit2;
    end else begin
      bus.rd_data1 = regs_q[bus.rd_addr1];
      bus.rd_data2 = regs_q[bus.rd_addr2];
      bus.rd_busy1 = pend_q[bus.rd_addr1];
      bus.rd_busy2 = pend_q[bus.rd_addr2];
    end
    bus.pc_rd = regs_q[PC_A];
  end
endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_gpr_file_sb;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpr_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
  gpr_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

  assign bus_n.rd_addr1   = bus_b.rd_addr1;
  assign bus_n.rd_addr2   = bus_b.rd_addr2;
  assign bus_n.wr_en      = bus_b.wr_en;
  assign bus_n.wr_addr    = bus_b.wr_addr;
  assign bus_n.wr_data    = bus_b.wr_data;
  assign bus_n.pc_wr_en   = bus_b.pc_wr_en;
  assign bus_n.pc_wr_data = bus_b.pc_wr_data;
  assign bus_n.pend_en    = bus_b.pend_en;
  assign bus_n.pend_addr  = bus_b.pend_addr;
  assign bus_n.flush      = bus_b.flush;

  gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(7), .RESET_PC(16'h0010), .BYPASS(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(7), .RESET_PC(16'h0010), .BYPASS(0))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] got_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic expect_v(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic obs(input logic [15:0] v);
    got_q.push_back(v);
  endtask

  task automatic idle();
    bus_b.rd_addr1   = '0;
    bus_b.rd_addr2   = '0;
    bus_b.wr_en      = 1'b0;
    bus_b.wr_addr    = '0;
    bus_b.wr_data    = '0;
    bus_b.pc_wr_en   = 1'b0;
    bus_b.pc_wr_data = '0;
    bus_b.pend_en    = 1'b0;
    bus_b.pend_addr  = '0;
    bus_b.flush      = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] g;
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_b.rd_addr1 = 3'(a);
      bus_b.rd_addr2 = 3'(7 - a);
      expect_v("rst_b_rd1", (a == 7) ? 16'h0010 : 16'h0000);
      expect_v("rst_b_rd2", (a == 0) ? 16'h0010 : 16'h0000);
      expect_v("rst_n_rd1", (a == 7) ? 16'h0010 : 16'h0000);
      expect_v("rst_b_pc", 16'h0010);
      expect_v("rst_b_busy1", 16'h0000);
      expect_v("rst_n_busy2", 16'h0000);
      #1;
      obs(bus_b.rd_data1); obs(bus_b.rd_data2); obs(bus_n.rd_data1);
      obs(bus_b.pc_rd); obs({15'b0, bus_b.rd_busy1}); obs({15'b0, bus_n.rd_busy2});
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  task automatic test_write_bypass();
    exp_t e;
    logic [15:0] g;
    @(negedge clk); idle();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd3; bus_b.wr_data = 16'hBEEF;
    bus_b.rd_addr1 = 3'd3; bus_b.rd_addr2 = 3'd3;
    expect_v("wb_b_rd1", 16'hBEEF); expect_v("wb_b_rd2", 16'hBEEF);
    expect_v("wb_n_rd1", 16'h0000); expect_v("wb_n_rd2", 16'h0000);
    #1;
    obs(bus_b.rd_data1); obs(bus_b.rd_data2); obs(bus_n.rd_data1); obs(bus_n.rd_data2);
    @(negedge clk); idle(); bus_b.rd_addr1 = 3'd3;
    expect_v("wb_b_rd1_next", 16'hBEEF); expect_v("wb_n_rd1_next", 16'hBEEF);
    #1;
    obs(bus_b.rd_data1); obs(bus_n.rd_data1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  task automatic test_pc_priority();
    exp_t e;
    logic [15:0] g;
    @(negedge clk); idle();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd7; bus_b.wr_data = 16'h0040;
    bus_b.pc_wr_en = 1'b1; bus_b.pc_wr_data = 16'h0012; bus_b.rd_addr1 = 3'd7;
    expect_v("pc_b_rd1_byp", 16'h0040); expect_v("pc_b_pc_nobyp", 16'h0010);
    expect_v("pc_n_rd1", 16'h0010);
    #1;
    obs(bus_b.rd_data1); obs(bus_b.pc_rd); obs(bus_n.rd_data1);
    @(negedge clk); idle(); bus_b.rd_addr1 = 3'd7;
    expect_v("pc_b_pc_wb", 16'h0040); expect_v("pc_n_pc_wb", 16'h0040);
    expect_v("pc_n_rd1_wb", 16'h0040);
    #1;
    obs(bus_b.pc_rd); obs(bus_n.pc_rd); obs(bus_n.rd_data1);
    @(negedge clk); idle();
    bus_b.pc_wr_en = 1'b1; bus_b.pc_wr_data = 16'h0044; bus_b.rd_addr1 = 3'd7;
    bus_b.pend_en = 1'b1; bus_b.pend_addr = 3'd7;
    expect_v("pc_b_rd1_fetch", 16'h0044); expect_v("pc_b_pc_hold", 16'h0040);
    #1;
    obs(bus_b.rd_data1); obs(bus_b.pc_rd);
    @(negedge clk); idle(); bus_b.rd_addr1 = 3'd7; bus_b.rd_addr2 = 3'd7;
    expect_v("pc_b_pc_fetch", 16'h0044); expect_v("pc_b_busy2_pc", 16'h0000);
    expect_v("pc_n_busy1_pc", 16'h0000);
    #1;
    obs(bus_b.pc_rd); obs({15'b0, bus_b.rd_busy2}); obs({15'b0, bus_n.rd_busy1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [15:0] g;
    @(negedge clk); idle();
    bus_b.pend_en = 1'b1; bus_b.pend_addr = 3'd5; bus_b.rd_addr2 = 3'd5;
    expect_v("sb_busy_issue_cycle", 16'h0000);
    #1; obs({15'b0, bus_b.rd_busy2});
    @(negedge clk); idle(); bus_b.rd_addr2 = 3'd5;
    expect_v("sb_b_busy", 16'h0001); expect_v("sb_n_busy", 16'h0001);
    #1; obs({15'b0, bus_b.rd_busy2}); obs({15'b0, bus_n.rd_busy2});
    @(negedge clk); idle(); bus_b.rd_addr2 = 3'd5;
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd5; bus_b.wr_data = 16'h1234;
    expect_v("sb_b_busy_wb", 16'h0000); expect_v("sb_n_busy_wb", 16'h0001);
    expect_v("sb_b_rd2_wb", 16'h1234);
    #1; obs({15'b0, bus_b.rd_busy2}); obs({15'b0, bus_n.rd_busy2}); obs(bus_b.rd_data2);
    @(negedge clk); idle(); bus_b.rd_addr2 = 3'd5;
    expect_v("sb_b_busy_after", 16'h0000); expect_v("sb_n_busy_after", 16'h0000);
    #1; obs({15'b0, bus_b.rd_busy2}); obs({15'b0, bus_n.rd_busy2});
    @(negedge clk); idle();
    bus_b.pend_en = 1'b1; bus_b.pend_addr = 3'd5;
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd5; bus_b.wr_data = 16'h5555;
    @(negedge clk); idle(); bus_b.rd_addr2 = 3'd5;
    expect_v("sb_b_set_beats_clr", 16'h0001); expect_v("sb_n_set_beats_clr", 16'h0001);
    #1; obs({15'b0, bus_b.rd_busy2}); obs({15'b0, bus_n.rd_busy2});
    @(negedge clk); idle();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd5; bus_b.wr_data = 16'h5556;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    logic [15:0] g;
    logic [2:0] regs [3];
    regs[0] = 3'd1; regs[1] = 3'd2; regs[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle();
      bus_b.pend_en = 1'b1; bus_b.pend_addr = regs[i];
    end
    @(negedge clk); idle();
    bus_b.flush = 1'b1; bus_b.pend_en = 1'b1; bus_b.pend_addr = 3'd6;
    bus_b.rd_addr1 = 3'd1; bus_b.rd_addr2 = 3'd4;
    expect_v("fl_b_busy1_pre", 16'h0001); expect_v("fl_b_busy2_pre", 16'h0001);
    #1; obs({15'b0, bus_b.rd_busy1}); obs({15'b0, bus_b.rd_busy2});
    @(negedge clk); idle(); bus_b.rd_addr1 = 3'd1; bus_b.rd_addr2 = 3'd2;
    expect_v("fl_b_busy_r1", 16'h0000); expect_v("fl_b_busy_r2", 16'h0000);
    expect_v("fl_n_busy_r1", 16'h0000);
    #1; obs({15'b0, bus_b.rd_busy1}); obs({15'b0, bus_b.rd_busy2}); obs({15'b0, bus_n.rd_busy1});
    @(negedge clk); idle(); bus_b.rd_addr1 = 3'd4; bus_b.rd_addr2 = 3'd6;
    expect_v("fl_b_busy_r4", 16'h0000); expect_v("fl_b_busy_r6_noset", 16'h0000);
    #1; obs({15'b0, bus_b.rd_busy1}); obs({15'b0, bus_b.rd_busy2});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] g;
    logic [15:0] d;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk); idle();
      d = 16'($urandom);
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'(r); bus_b.wr_data = d;
      expect_v($sformatf("b2b_b_rd1_r%0d", r), d);
      expect_v($sformatf("b2b_n_rd2_r%0d", r), d);
    end
    for (int r = 0; r < 7; r++) begin
      @(negedge clk); idle();
      bus_b.rd_addr1 = 3'(r); bus_b.rd_addr2 = 3'(r);
      #1; obs(bus_b.rd_data1); obs(bus_n.rd_data2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [15:0] g;
    @(negedge clk); idle();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd2; bus_b.wr_data = 16'hAAAA;
    bus_b.pend_en = 1'b1; bus_b.pend_addr = 3'd3;
    @(negedge clk); idle();
    rst = 1'b1;
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd2; bus_b.wr_data = 16'h5A5A;
    bus_b.pc_wr_en = 1'b1; bus_b.pc_wr_data = 16'h0077;
    bus_b.pend_en = 1'b1; bus_b.pend_addr = 3'd4; bus_b.rd_addr2 = 3'd3;
    expect_v("rm_b_busy_pre", 16'h0001);
    #1; obs({15'b0, bus_b.rd_busy2});
    @(negedge clk); idle(); rst = 1'b0;
    bus_b.rd_addr1 = 3'd2; bus_b.rd_addr2 = 3'd3;
    expect_v("rm_b_rd_r2", 16'h0000); expect_v("rm_n_rd_r2", 16'h0000);
    expect_v("rm_b_pc", 16'h0010); expect_v("rm_n_pc", 16'h0010);
    expect_v("rm_b_busy_r3", 16'h0000);
    #1;
    obs(bus_b.rd_data1); obs(bus_n.rd_data1); obs(bus_b.pc_rd); obs(bus_n.pc_rd);
    obs({15'b0, bus_b.rd_busy2});
    @(negedge clk); idle(); bus_b.rd_addr2 = 3'd4;
    expect_v("rm_b_busy_r4", 16'h0000);
    #1; obs({15'b0, bus_b.rd_busy2});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (g !== e.val) begin n_err++; $display("FAIL %s: got %h, want %h", e.tag, g, e.val); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_bypass();
    test_pc_priority();
    test_scoreboard();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
